fir_mac_sequencer: RTL and testbench
====================================

// Module: fir_mac_sequencer
// PURPOSE
//   Time-multiplexed FIR controller and datapath: one shared multiplier-accumulator is stepped over N_TAPS taps per input sample.
//   Holds a runtime-loadable coefficient bank and the sample delay line, sequences the MAC, and emits one output per accepted sample.
//   Sits between the pin-level top (x_in/y_out nibbles) and replaces the fixed two-tap differentiator's hardwired coefficients.
// PARAMETERS
//   N_TAPS   4  number of taps / MAC steps per sample (>=2)
//   BW_in    2  signed input sample width
//   BW_coef  2  signed coefficient width
//   BW_acc   6  signed accumulator width (= BW_in+BW_coef+clog2(N_TAPS))
//   BW_out   4  output width; y_out = acc[BW_acc-1 -: BW_out]
// PORTS
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous, active-high
//   x_in       in   BW_in    signed input sample
//   x_valid    in   1        sample offered
//   x_ready    out  1        sample accepted on edge where x_valid&&x_ready
//   cfg_en     in   1        coefficient load strobe, one word per cycle
//   cfg_data   in   BW_coef  signed coefficient word
//   y_out      out  BW_out   signed filter output (registered)
//   y_valid    out  1        one-cycle pulse, y_out new
//   busy       out  1        high in MAC or DONE
// BEHAVIOUR
//   Reset: state IDLE; delay line d[*]=0; acc=0; tap=0; y_out=0; y_valid=0; coef[0]=-1, coef[1]=+1, coef[2..]=0.
//   Reset mid-operation aborts any MAC/CFG; same values next cycle; coefs revert to default.
//   States IDLE, CFG, MAC, DONE.
//   x_ready = (state==IDLE) && !cfg_en (combinational). busy = state in {MAC,DONE}.
//   IDLE: cfg_en -> shift word, go CFG (cfg has priority over x_valid same cycle; sample not taken).
//         else x_valid -> d[0]<=x_in, d[k]<=d[k-1]; acc<=0; tap<=0; go MAC.
//   CFG: each edge with cfg_en: coef[N_TAPS-1]<=cfg_data, coef[k]<=coef[k+1] (first word of N lands in coef[0]).
//        >N words: oldest discarded; <N words: partial shift, no error. cfg_en low -> IDLE. Delay line untouched.
//   MAC: per edge acc <= acc + sxt(coef[tap]*d[tap]); product width BW_in+BW_coef, sign-extended; acc wraps mod 2^BW_acc.
//        tap==N_TAPS-1 -> DONE. x_valid and cfg_en ignored (cfg words lost).
//   DONE: y_out <= acc[BW_acc-1 -: BW_out] (arithmetic truncation, no rounding); y_valid<=1; go IDLE.
//   y_valid cleared on every edge not leaving DONE; y_out holds between pulses.
//   Latency: accept edge T -> y_valid high in cycle after edge T+N_TAPS+1. Max throughput 1 sample / (N_TAPS+2) cycles.
//   A new sample may be accepted in the y_valid cycle.
// STRUCTURE
//   Shared package fir_pkg: state encoding constants, default coefficient vector, clog2 function.
//   Sub-module fir_mac: signed multiply + accumulate with clear/enable; sequencer owns FSM, tap counter, coef bank, delay line.
// TESTING
//   1 Defaults: reset, samples x=1 then x=0 -> y_out 4'hF (acc=-1) then 4'h0; y_valid pulses 6 cycles apart.
//   2 Load: cfg_data -2,-2,-2,-2 over 4 cycles; then x=-2 x4 -> y_out 1,2,3,4 (acc 4,8,12,16).
//   3 Handshake: x_valid held high -> exactly one acceptance per 6 cycles; x_ready=0, busy=1 during MAC/DONE.
//   4 Collision: cfg_en and x_valid same IDLE cycle -> x_ready=0, coef shifted, no y_valid follows.
//   5 Abort: reset asserted at 2nd MAC cycle -> next cycle all outputs at reset values, no y_valid; coefs default.
//   6 Over-length cfg: words 1,0,-1,-2,1,-1 -> coef = {-1,-2,1,-1}; impulse x=1 -> y_out from acc=-1.

Source files
------------

// File: rtl/fir_pkg.sv
// ============================================================================
// Module : fir_pkg
// Brief  : Shared FIR sequencer state encoding, default coefficients, clog2.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fir_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_CFG  = 2'd1;
   localparam state_t ST_MAC  = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Reset coefficient bank reproduces the old two-tap differentiator y = x[n-1] - x[n].
   function automatic int default_coef(input int k);
      return (k == 0) ? -1 : ((k == 1) ? 1 : 0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fir_mac.sv
// ============================================================================
// Module : fir_mac
// Brief  : Signed multiply-accumulate with clear/enable; exposes the top bits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_mac #(
   parameter int BW_A   = 2,
   parameter int BW_B   = 2,
   parameter int BW_ACC = 6,
   parameter int BW_OUT = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     en,
   input  logic signed [BW_A-1:0]   a,
   input  logic signed [BW_B-1:0]   b,
   output logic signed [BW_OUT-1:0] acc_hi
);

   localparam int BW_P = BW_A + BW_B;

   logic signed [BW_P-1:0]   prod;
   logic signed [BW_ACC-1:0] acc_q;
   logic signed [BW_ACC-1:0] acc_d;

   // Full-width product is sign-extended into the accumulator, which wraps.
   always_comb begin
      prod  = BW_P'(a) * BW_P'(b);
      acc_d = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + BW_ACC'(prod);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_hi = acc_q[BW_ACC-1 -: BW_OUT];

endmodule

`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
// ============================================================================
// Module : fir_mac_sequencer
// Brief  : Time-multiplexed FIR: loadable coefficient bank, delay line, MAC sequencing.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_mac_sequencer
   import fir_pkg::*;
#(
   parameter int N_TAPS  = 4,
   parameter int BW_in   = 2,
   parameter int BW_coef = 2,
   parameter int BW_acc  = 6,
   parameter int BW_out  = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic signed [BW_in-1:0]   x_in,
   input  logic                      x_valid,
   output logic                      x_ready,
   input  logic                      cfg_en,
   input  logic signed [BW_coef-1:0] cfg_data,
   output logic signed [BW_out-1:0]  y_out,
   output logic                      y_valid,
   output logic                      busy
);

   localparam int TAP_W = (clog2(N_TAPS) < 1) ? 1 : clog2(N_TAPS);
   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(N_TAPS - 1);

   state_t                    state_q;
   state_t                    state_d;
   logic signed [BW_coef-1:0] coef_q [N_TAPS];
   logic signed [BW_coef-1:0] coef_d [N_TAPS];
   logic signed [BW_in-1:0]   dly_q  [N_TAPS];
   logic signed [BW_in-1:0]   dly_d  [N_TAPS];
   logic [TAP_W-1:0]          tap_q;
   logic [TAP_W-1:0]          tap_d;
   logic signed [BW_out-1:0]  y_out_q;
   logic signed [BW_out-1:0]  y_out_d;
   logic                      y_valid_q;
   logic                      y_valid_d;

   logic                      accept;
   logic                      cfg_shift;
   logic                      mac_en;
   logic signed [BW_out-1:0]  acc_hi;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a cfg strobe in IDLE wins over an offered sample
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg_en) begin
               state_d = ST_CFG;
            end else if (x_valid) begin
               state_d = ST_MAC;
            end
         end
         ST_CFG:  if (!cfg_en) state_d = ST_IDLE;
         ST_MAC:  if (tap_q == LAST_TAP) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      x_ready   = (state_q == ST_IDLE) && !cfg_en;
      busy      = (state_q == ST_MAC) || (state_q == ST_DONE);
      accept    = x_ready && x_valid;
      cfg_shift = cfg_en && ((state_q == ST_IDLE) || (state_q == ST_CFG));
      mac_en    = (state_q == ST_MAC);
   end

   always_comb begin
      coef_d = coef_q;
      dly_d  = dly_q;
      if (cfg_shift) begin
         for (int k = 0; k < N_TAPS - 1; k++) coef_d[k] = coef_q[k + 1];
         coef_d[N_TAPS-1] = cfg_data;
      end
      if (accept) begin
         for (int k = 1; k < N_TAPS; k++) dly_d[k] = dly_q[k - 1];
         dly_d[0] = x_in;
      end
   end

   always_comb begin
      tap_d     = tap_q;
      y_out_d   = y_out_q;
      y_valid_d = 1'b0;
      if (accept) begin
         tap_d = '0;
      end else if (mac_en) begin
         tap_d = tap_q + TAP_W'(1);
      end
      if (state_q == ST_DONE) begin
         y_out_d   = acc_hi;
         y_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < N_TAPS; k++) begin
            coef_q[k] <= BW_coef'(default_coef(k));
            dly_q[k]  <= '0;
         end
         tap_q     <= '0;
         y_out_q   <= '0;
         y_valid_q <= 1'b0;
      end else begin
         coef_q    <= coef_d;
         dly_q     <= dly_d;
         tap_q     <= tap_d;
         y_out_q   <= y_out_d;
         y_valid_q <= y_valid_d;
      end
   end

   fir_mac #(
      .BW_A   (BW_in),
      .BW_B   (BW_coef),
      .BW_ACC (BW_acc),
      .BW_OUT (BW_out)
   ) u_mac (
      .clk    (clk),
      .reset  (reset),
      .clear  (accept),
      .en     (mac_en),
      .a      (dly_q[tap_q]),
      .b      (coef_q[tap_q]),
      .acc_hi (acc_hi)
   );

   assign y_out   = y_out_q;
   assign y_valid = y_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
// ============================================================================
// Module : tb_fir_mac_sequencer
// Brief  : Directed + random bench for fir_mac_sequencer against a sum-of-products model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fir_mac_sequencer;

   localparam int N = 4;

   logic       clk;
   logic       reset;
   logic [1:0] x_in;
   logic       x_valid;
   logic       x_ready;
   logic       cfg_en;
   logic [1:0] cfg_data;
   logic [3:0] y_out;
   logic       y_valid;
   logic       busy;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int acc_cnt  = 0;
   bit acc_seen = 0;

   int         coef_m [N];
   int         dly_m  [N];
   logic [3:0] exp_y[$];
   int         exp_cyc[$];
   int         y_cyc[$];

   fir_mac_sequencer dut (
      .clk      (clk),
      .reset    (reset),
      .x_in     (x_in),
      .x_valid  (x_valid),
      .x_ready  (x_ready),
      .cfg_en   (cfg_en),
      .cfg_data (cfg_data),
      .y_out    (y_out),
      .y_valid  (y_valid),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int sx2(input logic [1:0] v);
      return v[1] ? int'(v) - 4 : int'(v);
   endfunction

   function automatic logic [3:0] model_y();
      int s;
      s = 0;
      for (int k = 0; k < N; k++) s += coef_m[k] * dly_m[k];
      s = s & 63;
      return 4'(s >> 2);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         coef_m[k] = (k == 0) ? -1 : ((k == 1) ? 1 : 0);
         dly_m[k]  = 0;
      end
      exp_y.delete();
      exp_cyc.delete();
   endtask

   task automatic model_cfg(input int w);
      for (int k = 0; k < N - 1; k++) coef_m[k] = coef_m[k + 1];
      coef_m[N-1] = w;
   endtask

   // One clock: observe handshake/output at the falling edge, then consume the rising edge.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (x_valid && x_ready) begin
         for (int k = N - 1; k > 0; k--) dly_m[k] = dly_m[k - 1];
         dly_m[0] = sx2(x_in);
         exp_y.push_back(model_y());
         exp_cyc.push_back(cyc);
         acc_seen = 1;
         acc_cnt++;
      end
      if (y_valid) begin
         y_cyc.push_back(cyc);
         if (exp_y.size() == 0) begin
            check("spurious_y_valid", 32'(y_valid), 0);
         end else begin
            check("y_out", 32'(y_out), 32'(exp_y.pop_front()));
            check("latency", cyc - exp_cyc.pop_front(), N + 2);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; x_valid = 1'b0; cfg_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic send(input int x);
      int n;
      n = 0;
      acc_seen = 0;
      x_in = 2'(x);
      x_valid = 1'b1;
      do begin
         tick();
         n++;
      end while (!acc_seen && n < 20);
      x_valid = 1'b0;
      check("accept_seen", 32'(acc_seen), 1);
   endtask

   task automatic drain(input int n);
      repeat (n) tick();
      check("no_pending_output", exp_y.size(), 0);
   endtask

   task automatic cfg_load(input int w[$]);
      foreach (w[i]) begin
         cfg_en = 1'b1;
         cfg_data = 2'(w[i]);
         #1;
         check("cfg_x_ready", 32'(x_ready), 0);
         tick();
         model_cfg(w[i]);
      end
      cfg_en = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1; x_in = '0; x_valid = 1'b0; cfg_en = 1'b0; cfg_data = '0;
      do_reset();

      // 1: reset values and default differentiator
      check("rst_y_out", 32'(y_out), 0);
      check("rst_y_valid", 32'(y_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_x_ready", 32'(x_ready), 1);
      y_cyc.delete();
      send(1);
      send(0);
      drain(8);
      check("pulse_count", y_cyc.size(), 2);
      if (y_cyc.size() == 2) check("pulse_spacing", y_cyc[1] - y_cyc[0], N + 2);

      // 2: coefficient load then constant input
      do_reset();
      cfg_load('{-2, -2, -2, -2});
      repeat (4) send(-2);
      drain(8);

      // 3: x_valid held high, handshake rate and busy/ready relation
      acc_cnt = 0;
      x_valid = 1'b1;
      for (int i = 0; i < 24; i++) begin
         x_in = 2'($urandom_range(0, 3));
         #1;
         check("ready_vs_busy", 32'(x_ready), 32'(!busy));
         tick();
      end
      x_valid = 1'b0;
      check("accepts_in_24", acc_cnt, 4);
      drain(8);

      // cfg words during MAC/DONE are dropped
      x_in = 2'(1);
      x_valid = 1'b1;
      tick();
      x_valid = 1'b0;
      cfg_en = 1'b1;
      for (int i = 0; i < N + 1; i++) begin
         cfg_data = 2'($urandom_range(0, 3));
         #1;
         check("busy_in_mac", 32'(busy), 1);
         tick();
      end
      cfg_en = 1'b0;
      drain(4);
      send(-1);
      drain(8);

      // 4: cfg and sample in the same IDLE cycle
      cfg_en = 1'b1; cfg_data = 2'(1); x_valid = 1'b1; x_in = 2'(1);
      #1;
      check("collision_x_ready", 32'(x_ready), 0);
      tick();
      model_cfg(1);
      cfg_en = 1'b0; x_valid = 1'b0;
      drain(8);
      send(1);
      drain(8);

      // 5: reset during the second MAC cycle
      do_reset();
      send(1);
      drain(8);
      x_in = 2'(1);
      x_valid = 1'b1;
      tick();
      x_valid = 1'b0;
      tick();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("abort_y_out", 32'(y_out), 0);
      check("abort_y_valid", 32'(y_valid), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_x_ready", 32'(x_ready), 1);
      model_reset();
      drain(8);
      send(1);
      drain(8);

      // 6: over-length configuration keeps the last N words
      do_reset();
      cfg_load('{1, 0, -1, -2, 1, -1});
      send(1);
      drain(8);

      // random configurations and samples
      for (int r = 0; r < 4; r++) begin
         int words[$];
         int nw;
         nw = $urandom_range(1, 6);
         words.delete();
         for (int i = 0; i < nw; i++) words.push_back($urandom_range(0, 3) - 2);
         cfg_load(words);
         for (int s = 0; s < 5; s++) begin
            send($urandom_range(0, 3) - 2);
            repeat ($urandom_range(0, 3)) tick();
         end
         drain(8);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
